// File: rtl/addr_decode_prog_multi.sv
// addr_decode_prog_multi: programmable N-window fetch address decoder with registered one-hot select and fault log
// Ports: clk, rst_n (async, active low); req_valid_i/req_addr_i request; cfg_we_i/cfg_sel_i/cfg_is_limit_i/cfg_data_i
// table write; cfg_lock_i freezes table until reset; fault_clr_i clears fault state; rsp_valid_o/hit_o/cs_o/local_addr_o
// registered decode; fault_sticky_o/fault_addr_o/fault_cause_o/fault_count_o fault log.
// Optional feature: define ADDR_DEC_ALIGN_CHECK_EN to fault word-misaligned requests (cause 10).
module addr_decode_prog_multi #(
  parameter int AW = 32,
  parameter int N_REGIONS = 4,
  parameter int CW = 8,
  parameter logic [AW-1:0] DEF_BASE0 = 32'h18C0,
  parameter logic [AW-1:0] DEF_LIMIT0 = 32'h1CBF,
  localparam int SW = N_REGIONS > 1 ? $clog2(N_REGIONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  input  logic [AW-1:0]        req_addr_i,
  input  logic                 cfg_we_i,
  input  logic [SW-1:0]        cfg_sel_i,
  input  logic                 cfg_is_limit_i,
  input  logic [AW-1:0]        cfg_data_i,
  input  logic                 cfg_lock_i,
  input  logic                 fault_clr_i,
  output logic                 rsp_valid_o,
  output logic                 hit_o,
  output logic [N_REGIONS-1:0] cs_o,
  output logic [AW-1:0]        local_addr_o,
  output logic                 fault_sticky_o,
  output logic [AW-1:0]        fault_addr_o,
  output logic [1:0]           fault_cause_o,
  output logic [CW-1:0]        fault_count_o
);
  logic [AW-1:0] base_q [N_REGIONS];
  logic [AW-1:0] limit_q [N_REGIONS];
  logic [AW-1:0] base_d [N_REGIONS];
  logic [AW-1:0] limit_d [N_REGIONS];
  logic lock_q, lock_d, cfg_wr;
  logic win_hit, mis, hit_c, fault;
  logic [N_REGIONS-1:0] win_cs;
  logic [AW-1:0] win_off;
  logic rsp_valid_q, rsp_valid_d, hit_q, hit_d, sticky_q, sticky_d;
  logic [N_REGIONS-1:0] cs_q, cs_d;
  logic [AW-1:0] local_q, local_d, faddr_q, faddr_d;
  logic [1:0] cause_q, cause_d;
  logic [CW-1:0] count_q, count_d, count_inc;
`ifdef ADDR_DEC_ALIGN_CHECK_EN
  assign mis = req_addr_i[1:0] != 2'b00;
`else
  assign mis = 1'b0;
`endif
  assign cfg_wr = cfg_we_i && !lock_q && (int'(cfg_sel_i) < N_REGIONS);
  assign lock_d = lock_q | cfg_lock_i;
  always_comb begin
    for (int i = 0; i < N_REGIONS; i++) begin
      base_d[i] = (cfg_wr && !cfg_is_limit_i && cfg_sel_i == SW'(i)) ? cfg_data_i : base_q[i];
      limit_d[i] = (cfg_wr && cfg_is_limit_i && cfg_sel_i == SW'(i)) ? cfg_data_i : limit_q[i];
    end
  end
  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    win_hit = 1'b0;
    win_cs = '0;
    win_off = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (base_q[i] <= req_addr_i && req_addr_i <= limit_q[i]) begin
        win_hit = 1'b1;
        win_cs = '0;
        win_cs[i] = 1'b1;
        win_off = req_addr_i - base_q[i];
      end
    end
  end
  assign hit_c = req_valid_i && win_hit && !mis;
  assign fault = req_valid_i && !hit_c;
  assign count_inc = (count_q == {CW{1'b1}}) ? count_q : count_q + CW'(1);
  always_comb begin
    rsp_valid_d = req_valid_i;
    hit_d = hit_c;
    cs_d = hit_c ? win_cs : '0;
    local_d = hit_c ? win_off : '0;
    // A fault in the same cycle as fault_clr restarts the log at one entry.
    sticky_d = fault ? 1'b1 : fault_clr_i ? 1'b0 : sticky_q;
    faddr_d = fault ? req_addr_i : faddr_q;
    cause_d = fault ? (mis ? 2'b10 : 2'b01) : fault_clr_i ? 2'b00 : cause_q;
    count_d = fault ? (fault_clr_i ? CW'(1) : count_inc) : fault_clr_i ? '0 : count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGIONS; i++) begin
        base_q[i] <= (i == 0) ? DEF_BASE0 : {AW{1'b1}};
        limit_q[i] <= (i == 0) ? DEF_LIMIT0 : '0;
      end
      lock_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      hit_q <= 1'b0;
      cs_q <= '0;
      local_q <= '0;
      sticky_q <= 1'b0;
      faddr_q <= '0;
      cause_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < N_REGIONS; i++) begin
        base_q[i] <= base_d[i];
        limit_q[i] <= limit_d[i];
      end
      lock_q <= lock_d;
      rsp_valid_q <= rsp_valid_d;
      hit_q <= hit_d;
      cs_q <= cs_d;
      local_q <= local_d;
      sticky_q <= sticky_d;
      faddr_q <= faddr_d;
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end
  assign rsp_valid_o = rsp_valid_q;
  assign hit_o = hit_q;
  assign cs_o = cs_q;
  assign local_addr_o = local_q;
  assign fault_sticky_o = sticky_q;
  assign fault_addr_o = faddr_q;
  assign fault_cause_o = cause_q;
  assign fault_count_o = count_q;
endmodule
